// File: rtl/dk_sound_pkg.sv
// Shared types and default timing constants for the sound-effect voice logic.
// Durations are expressed in audio sample ticks.
package dk_sound_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      HOLD = 2'd2,
      GAP  = 2'd3
   } sfx_state_t;

   function automatic int ms_to_samples(input int ms, input int rate);
      return (ms * rate) / 1000;
   endfunction

   localparam int SFX_RATE   = 48000;
   localparam int SFX_MIN_ON = ms_to_samples(50, SFX_RATE);
   localparam int SFX_MAX_ON = ms_to_samples(1000, SFX_RATE);
   localparam int SFX_GAP    = ms_to_samples(2, SFX_RATE);

endpackage

// File: rtl/dk_sfx_channel_fsm.sv
// One effect channel: request sync, stuck-bit lockout, on/hold/gap sequencing.
// Timers advance only on sample ticks; the timeout flag is sticky.
module dk_sfx_channel_fsm
   import dk_sound_pkg::*;
#(
   parameter int MIN_ON_SAMPLES = SFX_MIN_ON,
   parameter int MAX_ON_SAMPLES = SFX_MAX_ON,
   parameter int GAP_SAMPLES    = SFX_GAP
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_tick,
   input  logic i_req,
   input  logic i_grant,
   input  logic i_clear_timeout,
   output logic o_cand,
   output logic o_busy,
   output logic o_busy_nxt,
   output logic o_en,
   output logic o_timeout
);

   localparam int TMAX = (MAX_ON_SAMPLES > GAP_SAMPLES) ?
                         MAX_ON_SAMPLES : GAP_SAMPLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] L_MAX = TW'(MAX_ON_SAMPLES - 1);
   localparam logic [TW-1:0] L_MIN = TW'(MIN_ON_SAMPLES - 1);
   localparam logic [TW-1:0] L_GAP = TW'(GAP_SAMPLES - 1);

   logic          r_sync;
   logic          r_req_s;
   logic          r_lockout;
   logic          r_timeout;
   logic          r_en;
   sfx_state_t    r_state;
   logic [TW-1:0] r_timer;

   sfx_state_t    w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic          w_hit_max;
   logic          w_on_nxt;

   // Two-flop synchroniser for the asynchronous latch request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync  <= 1'b0;
         r_req_s <= 1'b0;
      end else begin
         r_sync  <= i_req;
         r_req_s <= r_sync;
      end
   end

   // Per-tick sequencing: minimum envelope, stuck-bit cutoff, re-trigger gap.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_hit_max   = 1'b0;
      if (i_tick) begin
         unique case (r_state)
            IDLE: begin
               if (i_grant) begin
                  w_state_nxt = ON;
                  w_timer_nxt = '0;
               end
            end
            ON: begin
               w_timer_nxt = r_timer + 1'b1;
               if (r_timer == L_MAX) begin
                  w_state_nxt = GAP;
                  w_timer_nxt = '0;
                  w_hit_max   = 1'b1;
               end else if (!r_req_s) begin
                  if (r_timer >= L_MIN) begin
                     w_state_nxt = GAP;
                     w_timer_nxt = '0;
                  end else begin
                     w_state_nxt = HOLD;
                  end
               end
            end
            HOLD: begin
               w_timer_nxt = r_timer + 1'b1;
               if (r_req_s) begin
                  w_state_nxt = ON;
               end else if (r_timer == L_MIN) begin
                  w_state_nxt = GAP;
                  w_timer_nxt = '0;
               end
            end
            GAP: begin
               if (r_timer == L_GAP) begin
                  w_state_nxt = IDLE;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer + 1'b1;
               end
            end
         endcase
      end
   end

   assign w_on_nxt = (w_state_nxt == ON) || (w_state_nxt == HOLD);

   // State, timer and registered enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_en    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_en    <= w_on_nxt;
      end
   end

   // Lockout after a cutoff until the request is seen released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lockout <= 1'b0;
      end else if (w_hit_max) begin
         r_lockout <= 1'b1;
      end else if (!r_req_s) begin
         r_lockout <= 1'b0;
      end
   end

   // Sticky cutoff flag; a same-clock cutoff beats the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timeout <= 1'b0;
      end else if (w_hit_max) begin
         r_timeout <= 1'b1;
      end else if (i_clear_timeout) begin
         r_timeout <= 1'b0;
      end
   end

   assign o_cand     = (r_state == IDLE) && r_req_s && !r_lockout;
   assign o_busy     = (r_state == ON) || (r_state == HOLD);
   assign o_busy_nxt = w_on_nxt;
   assign o_en       = r_en;
   assign o_timeout  = r_timeout;

endmodule

// File: rtl/dk_sfx_voice_scheduler.sv
// Shares a few voice slots between effect requesters, lowest index first.
// Holds the grant arbitration and the registered active-voice count.
module dk_sfx_voice_scheduler
   import dk_sound_pkg::*;
#(
   parameter  int NUM_CH         = 4,
   parameter  int MAX_ACTIVE     = 2,
   parameter  int MIN_ON_SAMPLES = SFX_MIN_ON,
   parameter  int MAX_ON_SAMPLES = SFX_MAX_ON,
   parameter  int GAP_SAMPLES    = SFX_GAP,
   localparam int CW             = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              audio_clk_en,
   input  logic [NUM_CH-1:0] req,
   input  logic              clear_timeout,
   output logic [NUM_CH-1:0] en,
   output logic [CW-1:0]     active_count,
   output logic [NUM_CH-1:0] timeout_flag
);

   logic [NUM_CH-1:0] w_cand;
   logic [NUM_CH-1:0] w_busy;
   logic [NUM_CH-1:0] w_busy_nxt;
   logic [NUM_CH-1:0] w_grant;
   logic [CW-1:0]     w_cnt_nxt;
   logic [CW-1:0]     r_active_count;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dk_sfx_channel_fsm #(
         .MIN_ON_SAMPLES (MIN_ON_SAMPLES),
         .MAX_ON_SAMPLES (MAX_ON_SAMPLES),
         .GAP_SAMPLES    (GAP_SAMPLES)
      ) u_ch (
         .clk             (clk),
         .reset_n         (reset_n),
         .i_tick          (audio_clk_en),
         .i_req           (req[g]),
         .i_grant         (w_grant[g]),
         .i_clear_timeout (clear_timeout),
         .o_cand          (w_cand[g]),
         .o_busy          (w_busy[g]),
         .o_busy_nxt      (w_busy_nxt[g]),
         .o_en            (en[g]),
         .o_timeout       (timeout_flag[g])
      );
   end

   // Grant the lowest-index idle requesters into the slots free before this tick.
   always_comb begin
      int n_busy;
      int n_grant;
      n_busy  = 0;
      n_grant = 0;
      w_grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_busy[i]) n_busy++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (audio_clk_en && w_cand[i] &&
             (n_grant < MAX_ACTIVE - n_busy)) begin
            w_grant[i] = 1'b1;
            n_grant++;
         end
      end
   end

   // Population count of the channels that will be sounding after this clock.
   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
      end
   end

   // Active-voice count tracks the channel state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_active_count <= '0;
      end else begin
         r_active_count <= w_cnt_nxt;
      end
   end

   assign active_count = r_active_count;

endmodule

// File: tb/tb_dk_sfx_voice_scheduler.sv
// Directed and random stimulus for the voice scheduler against a
// duration-based reference model (enable spans, gaps, slot sharing).
module tb_dk_sfx_voice_scheduler;

   localparam int NCH  = 3;
   localparam int MAXA = 2;
   localparam int MINO = 4;
   localparam int MAXO = 16;
   localparam int GAPS = 2;

   logic       clk;
   logic       reset_n;
   logic       audio_clk_en;
   logic [2:0] req;
   logic       clear_timeout;
   logic [2:0] en;
   logic [1:0] active_count;
   logic [2:0] timeout_flag;

   int n_chk;
   int n_pass;
   int n_fail;

   bit   m_act [NCH];
   int   m_age [NCH];
   int   m_end [NCH];
   bit   m_lock[NCH];
   logic [2:0] m_flag;
   int   tick_n;

   dk_sfx_voice_scheduler #(
      .NUM_CH         (NCH),
      .MAX_ACTIVE     (MAXA),
      .MIN_ON_SAMPLES (MINO),
      .MAX_ON_SAMPLES (MAXO),
      .GAP_SAMPLES    (GAPS)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .audio_clk_en  (audio_clk_en),
      .req           (req),
      .clear_timeout (clear_timeout),
      .en            (en),
      .active_count  (active_count),
      .timeout_flag  (timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_act[i]  = 1'b0;
         m_age[i]  = 0;
         m_end[i]  = -1000;
         m_lock[i] = 1'b0;
      end
      m_flag = '0;
   endtask

   // One sample tick: each enabled span grows by one; it ends at the
   // cutoff length, or on release once the minimum length is reached.
   // Idle requesters then take the slots that were free before the tick.
   task automatic model_tick(input logic [2:0] r, input bit clr);
      int  nb;
      int  ng;
      bit  was[NCH];
      if (clr) m_flag = '0;
      tick_n++;
      nb = 0;
      for (int i = 0; i < NCH; i++) begin
         was[i] = m_act[i];
         if (m_act[i]) nb++;
         if (!r[i]) m_lock[i] = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
         if (m_act[i]) begin
            m_age[i]++;
            if (m_age[i] == MAXO) begin
               m_act[i]  = 1'b0;
               m_end[i]  = tick_n;
               m_flag[i] = 1'b1;
               m_lock[i] = r[i];
            end else if (!r[i] && m_age[i] >= MINO) begin
               m_act[i] = 1'b0;
               m_end[i] = tick_n;
            end
         end
      end
      ng = 0;
      for (int i = 0; i < NCH; i++) begin
         if (!was[i] && tick_n > m_end[i] + GAPS && r[i] &&
             !m_lock[i] && ng < MAXA - nb) begin
            m_act[i] = 1'b1;
            m_age[i] = 0;
            ng++;
         end
      end
   endtask

   function automatic logic [2:0] m_en();
      logic [2:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_act[i];
      return v;
   endfunction

   function automatic logic [1:0] m_cnt();
      int c;
      c = 0;
      for (int i = 0; i < NCH; i++) if (m_act[i]) c++;
      return 2'(c);
   endfunction

   // clr: 0 none, 1 pulse early in the period, 2 pulse on the tick edge
   task automatic tick(input logic [2:0] r, input int clr);
      req           = r;
      clear_timeout = (clr == 1);
      @(posedge clk); #1 clear_timeout = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      audio_clk_en  = 1'b1;
      clear_timeout = (clr == 2);
      @(posedge clk); #1;
      audio_clk_en  = 1'b0;
      clear_timeout = 1'b0;
      model_tick(r, clr != 0);
      chk($sformatf("en@%0d", tick_n), 32'(en), 32'(m_en()));
      chk($sformatf("cnt@%0d", tick_n), 32'(active_count), 32'(m_cnt()));
      chk($sformatf("flag@%0d", tick_n), 32'(timeout_flag), 32'(m_flag));
   endtask

   initial begin
      int on_cnt;
      logic [2:0] r;
      n_chk  = 0;
      n_pass = 0;
      n_fail = 0;
      tick_n = 0;
      reset_n       = 1'b0;
      audio_clk_en  = 1'b0;
      req           = '0;
      clear_timeout = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #3;
      chk("rst_en", 32'(en), 32'(0));
      chk("rst_cnt", 32'(active_count), 32'(0));
      chk("rst_flag", 32'(timeout_flag), 32'(0));
      #2 reset_n = 1'b1;
      @(posedge clk); #1;

      // short press: hold stretches it to the minimum length
      on_cnt = 0;
      for (int j = 0; j < 8; j++) begin
         tick((j < 2) ? 3'b001 : 3'b000, 0);
         if (en[0]) on_cnt++;
      end
      chk("s1_on_ticks", 32'(on_cnt), 32'(MINO));

      // long press below the cutoff
      on_cnt = 0;
      for (int j = 0; j < 15; j++) begin
         tick((j < 10) ? 3'b001 : 3'b000, 0);
         if (en[0]) on_cnt++;
      end
      chk("s2_on_ticks", 32'(on_cnt), 32'(10));

      // stuck bit: cutoff, lockout, clear racing the cutoff
      on_cnt = 0;
      for (int j = 0; j < 30; j++) begin
         tick(3'b010, (j == 16) ? 2 : 0);
         if (en[1]) on_cnt++;
      end
      chk("s3_on_ticks", 32'(on_cnt), 32'(MAXO));
      chk("s3_flag_set", 32'(timeout_flag), 32'(3'b010));
      tick(3'b000, 0);
      tick(3'b000, 1);
      chk("s3_flag_clr", 32'(timeout_flag), 32'(0));
      for (int j = 0; j < 3; j++) tick(3'b010, 0);
      chk("s3_relock", 32'(en), 32'(3'b010));
      for (int j = 0; j < 6; j++) tick(3'b000, 0);

      // slot contention
      tick(3'b111, 0);
      chk("s4_en", 32'(en), 32'(3'b011));
      chk("s4_cnt", 32'(active_count), 32'(2));
      for (int j = 0; j < 4; j++) tick(3'b111, 0);
      tick(3'b110, 0);
      chk("s4_drop", 32'(en), 32'(3'b010));
      tick(3'b110, 0);
      chk("s4_next", 32'(en), 32'(3'b110));
      for (int j = 0; j < 6; j++) tick(3'b000, 0);

      // brief release inside the minimum keeps the enable continuous
      on_cnt = 0;
      for (int j = 0; j < 15; j++) begin
         tick((j < 2 || (j > 2 && j < 9)) ? 3'b001 : 3'b000, 0);
         if (en[0]) on_cnt++;
      end
      chk("s5_on_ticks", 32'(on_cnt), 32'(9));

      // asynchronous reset mid-enable
      for (int j = 0; j < 3; j++) tick(3'b001, 0);
      #3 reset_n = 1'b0;
      #1;
      chk("s6_en", 32'(en), 32'(0));
      chk("s6_cnt", 32'(active_count), 32'(0));
      model_reset();
      @(posedge clk);
      #5 reset_n = 1'b1;
      @(posedge clk); #1;
      tick(3'b001, 0);
      chk("s6_rerise", 32'(en), 32'(3'b001));
      for (int j = 0; j < 6; j++) tick(3'b000, 0);

      // random request patterns
      r = '0;
      for (int j = 0; j < 300; j++) begin
         for (int b = 0; b < NCH; b++) begin
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         end
         tick(r, ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
